framebuffer_writer: RTL and testbench

FRAMEBUFFER_WRITER -- requirements
Module: framebuffer_writer

---
 rtl/framebuffer_writer_if.sv | 28 ++
 rtl/framebuffer_writer.sv | 173 +++++++++++++++++
 tb/tb_framebuffer_writer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_writer_if.sv
// Pixel stream in, BRAM write bus out, bundled between rasterizer and framebuffer writer.
interface framebuffer_writer_if #(
    parameter int COORD_WIDTH = 32,
    parameter int COLOR_WIDTH = 16,
    parameter int ADDR_WIDTH  = 16
);
    logic                          pix_valid;
    logic signed [COORD_WIDTH-1:0] pix_x;
    logic signed [COORD_WIDTH-1:0] pix_y;
    logic        [COLOR_WIDTH-1:0] pix_color;

    logic                          wr_en;
    logic        [ADDR_WIDTH-1:0]  wr_addr;
    logic        [COLOR_WIDTH-1:0] wr_data;
    logic                          wr_buf;

    // Rasterizer / testbench side: sources pixels, observes BRAM writes.
    modport master (
        output pix_valid, pix_x, pix_y, pix_color,
        input  wr_en, wr_addr, wr_data, wr_buf
    );

    // Framebuffer writer side: consumes pixels, drives BRAM writes.
    modport slave (
        input  pix_valid, pix_x, pix_y, pix_color,
        output wr_en, wr_addr, wr_data, wr_buf
    );
endinterface

// File: rtl/framebuffer_writer.sv
// Double-buffered framebuffer writer: clears the back buffer, writes clipped
// pixels through a 2-stage address pipeline, and swaps buffers on vsync.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | waiting for clear_start (or frame_done for a swap w/o drawing)
// CLEAR      | filling back buffer with latched color, one word per cycle
// ACCEPT     | accepting in-bounds pixels into the write pipeline
// DRAIN      | no new pixels; letting in-flight pipeline writes finish
// WAIT_VSYNC | pipeline empty; swap front/back buffers on vsync_in
module framebuffer_writer #(
    parameter int COORD_WIDTH = 32,
    parameter int FB_WIDTH    = 320,
    parameter int FB_HEIGHT   = 180,
    parameter int COLOR_WIDTH = 16,
    parameter int ADDR_WIDTH  = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   clear_start,
    input  logic [COLOR_WIDTH-1:0] clear_color,
    input  logic                   frame_done,
    input  logic                   vsync_in,
    framebuffer_writer_if.slave    bus,
    output logic                   disp_buf,
    output logic                   ready,
    output logic                   busy,
    output logic                   swap_done,
    output logic [15:0]            drop_count
);
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        ACCEPT     = 3'd2,
        DRAIN      = 3'd3,
        WAIT_VSYNC = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0]         LAST_ADDR  = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0]         ROW_STRIDE = ADDR_WIDTH'(FB_WIDTH);
    localparam logic signed [COORD_WIDTH-1:0] X_LIMIT    = COORD_WIDTH'(FB_WIDTH);
    localparam logic signed [COORD_WIDTH-1:0] Y_LIMIT    = COORD_WIDTH'(FB_HEIGHT);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  clear_cnt;
    logic [COLOR_WIDTH-1:0] clear_color_q;

    logic                   s1_valid;
    logic [ADDR_WIDTH-1:0]  s1_yoff;
    logic [ADDR_WIDTH-1:0]  s1_x;
    logic [COLOR_WIDTH-1:0] s1_color;
    logic                   s2_valid;
    logic [ADDR_WIDTH-1:0]  s2_addr;
    logic [COLOR_WIDTH-1:0] s2_data;

    logic                   wr_buf_q;
    logic                   in_bounds, accept, drop;
    logic                   wr_en_c;
    logic [ADDR_WIDTH-1:0]  wr_addr_c;
    logic [COLOR_WIDTH-1:0] wr_data_c;

    assign in_bounds = (bus.pix_x >= 0) && (bus.pix_x < X_LIMIT) &&
                       (bus.pix_y >= 0) && (bus.pix_y < Y_LIMIT);
    assign accept    = (state_q == ACCEPT) && bus.pix_valid && in_bounds;
    assign drop      = bus.pix_valid && !accept;

    assign bus.wr_en   = wr_en_c;
    assign bus.wr_addr = wr_addr_c;
    assign bus.wr_data = wr_data_c;
    assign bus.wr_buf  = wr_buf_q;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and state-derived outputs; clear writes take the bus
    // while in CLEAR, otherwise pipeline stage 2 drives it.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        busy      = 1'b1;
        wr_en_c   = s2_valid;
        wr_addr_c = s2_addr;
        wr_data_c = s2_data;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (clear_start)     state_d = CLEAR;
                else if (frame_done) state_d = DRAIN;
            end
            CLEAR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = clear_cnt;
                wr_data_c = clear_color_q;
                if (clear_cnt == LAST_ADDR) state_d = ACCEPT;
            end
            ACCEPT: begin
                ready = 1'b1;
                if (frame_done) state_d = DRAIN;
            end
            // Leave once stage 1 is empty: stage 2 finishes its write this cycle.
            DRAIN: begin
                if (!s1_valid) state_d = WAIT_VSYNC;
            end
            WAIT_VSYNC: begin
                if (vsync_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear address counter and latched fill color.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            clear_cnt     <= '0;
            clear_color_q <= '0;
        end else if (state_q == IDLE && clear_start) begin
            clear_cnt     <= '0;
            clear_color_q <= clear_color;
        end else if (state_q == CLEAR) begin
            clear_cnt     <= clear_cnt + ADDR_WIDTH'(1);
        end
    end

    // Two-stage pixel pipeline: row offset multiply, then address add.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
            s1_yoff  <= '0;
            s1_x     <= '0;
            s1_color <= '0;
            s2_valid <= 1'b0;
            s2_addr  <= '0;
            s2_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_yoff  <= bus.pix_y[ADDR_WIDTH-1:0] * ROW_STRIDE;
                s1_x     <= bus.pix_x[ADDR_WIDTH-1:0];
                s1_color <= bus.pix_color;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_addr <= s1_yoff + s1_x;
                s2_data <= s1_color;
            end
        end
    end

    // Saturating count of pixels that were clipped or arrived outside ACCEPT.
    always_ff @(posedge clk_in) begin
        if (rst_in)                         drop_count <= '0;
        else if (drop && drop_count != '1)  drop_count <= drop_count + 16'd1;
    end

    // Buffer swap on vsync once the frame is fully written.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_buf_q  <= 1'b1;
            disp_buf  <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= 1'b0;
            if (state_q == WAIT_VSYNC && vsync_in) begin
                disp_buf  <= wr_buf_q;
                wr_buf_q  <= ~wr_buf_q;
                swap_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_framebuffer_writer.sv
// Directed testbench for framebuffer_writer: clear, pixel pipeline, clipping,
// buffer swap, back-to-back pixels and reset abort.
module tb_framebuffer_writer;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        clear_start = 1'b0;
    logic [15:0] clear_color = '0;
    logic        frame_done = 1'b0;
    logic        vsync_in = 1'b0;
    logic        disp_buf, ready, busy, swap_done;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    framebuffer_writer_if #(.COORD_WIDTH(32), .COLOR_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    framebuffer_writer dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .frame_done  (frame_done),
        .vsync_in    (vsync_in),
        .bus         (bus),
        .disp_buf    (disp_buf),
        .ready       (ready),
        .busy        (busy),
        .swap_done   (swap_done),
        .drop_count  (drop_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_buf, disp_buf, ready, busy, swap_done, drop_count}
            !== {1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL reset_values got en=%b addr=%0d data=%h wbuf=%b dbuf=%b rdy=%b busy=%b swap=%b drop=%0d",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_buf, disp_buf, ready, busy, swap_done, drop_count);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({bus.wr_en, busy} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release_idle got en=%b busy=%b want 0 0", bus.wr_en, busy);
        end
    endtask

    task automatic test_clear();
        int good = 0;
        clear_start = 1'b1;
        clear_color = 16'h1234;
        @(negedge clk_in);
        clear_start = 1'b0;
        for (int i = 0; i < 57600; i++) begin
            if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_buf, ready, busy}
                === {1'b1, 16'(i), 16'h1234, 1'b1, 1'b0, 1'b1})
                good++;
            @(negedge clk_in);
        end
        checks++;
        if (good !== 57600) begin
            failures++;
            $display("FAIL clear_sequence got %0d correct words want 57600", good);
        end
        checks++;
        if ({ready, busy, bus.wr_en} !== 3'b110) begin
            failures++;
            $display("FAIL clear_to_accept got rdy=%b busy=%b en=%b want 1 1 0", ready, busy, bus.wr_en);
        end
    endtask

    task automatic test_pixel_write();
        bus.pix_valid = 1'b1;
        bus.pix_x     = 10;
        bus.pix_y     = 2;
        bus.pix_color = 16'hABCD;
        @(negedge clk_in);
        bus.pix_valid = 1'b0;
        checks++;
        if (bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL pixel_latency1 got en=%b want 0", bus.wr_en);
        end
        @(negedge clk_in);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 16'd650, 16'hABCD}) begin
            failures++;
            $display("FAIL pixel_write got en=%b addr=%0d data=%h want 1 650 abcd", bus.wr_en, bus.wr_addr, bus.wr_data);
        end
        @(negedge clk_in);
        checks++;
        if (bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL pixel_single got en=%b want 0", bus.wr_en);
        end
    endtask

    task automatic test_bounds();
        int xs [4] = '{-1, 320, 0, 319};
        int ys [4] = '{5, 0, 180, 179};
        int nwr = 0;
        logic [15:0] last_addr = '0;
        for (int c = 0; c < 8; c++) begin
            if (bus.wr_en === 1'b1) begin
                nwr++;
                last_addr = bus.wr_addr;
            end
            if (c < 4) begin
                bus.pix_valid = 1'b1;
                bus.pix_x     = xs[c];
                bus.pix_y     = ys[c];
                bus.pix_color = 16'(16'hB000 + c);
            end else begin
                bus.pix_valid = 1'b0;
            end
            @(negedge clk_in);
        end
        checks++;
        if (nwr !== 1) begin
            failures++;
            $display("FAIL bounds_write_count got %0d want 1", nwr);
        end
        checks++;
        if (last_addr !== 16'd57599) begin
            failures++;
            $display("FAIL bounds_addr got %0d want 57599", last_addr);
        end
        checks++;
        if (drop_count !== 16'd3) begin
            failures++;
            $display("FAIL bounds_drop_count got %0d want 3", drop_count);
        end
    endtask

    task automatic test_vsync_ignored();
        vsync_in = 1'b1;
        @(negedge clk_in);
        vsync_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({swap_done, disp_buf, bus.wr_buf, ready} !== 4'b0011) begin
                failures++;
                $display("FAIL vsync_in_accept got swap=%b dbuf=%b wbuf=%b rdy=%b want 0 0 1 1",
                         swap_done, disp_buf, bus.wr_buf, ready);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c <= 16; c++) begin
            if (c >= 2 && c <= 6) begin
                checks++;
                if ({bus.wr_en, bus.wr_addr, bus.wr_data} !== {1'b1, 16'(320 + c - 2), 16'(256 + c - 2)}) begin
                    failures++;
                    $display("FAIL b2b_write%0d got en=%b addr=%0d data=%h want 1 %0d %h",
                             c - 2, bus.wr_en, bus.wr_addr, bus.wr_data, 320 + c - 2, 256 + c - 2);
                end
            end else begin
                checks++;
                if (bus.wr_en !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_idle_bus c=%0d got en=%b want 0", c, bus.wr_en);
                end
            end
            if (c <= 14) begin
                checks++;
                if ({ready, busy, swap_done} !== {(c <= 4), 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL b2b_state c=%0d got rdy=%b busy=%b swap=%b want %b 1 0",
                             c, ready, busy, swap_done, (c <= 4));
                end
            end else if (c == 15) begin
                checks++;
                if ({swap_done, disp_buf, bus.wr_buf, busy} !== 4'b1100) begin
                    failures++;
                    $display("FAIL swap_pulse got swap=%b dbuf=%b wbuf=%b busy=%b want 1 1 0 0",
                             swap_done, disp_buf, bus.wr_buf, busy);
                end
            end else begin
                checks++;
                if (swap_done !== 1'b0) begin
                    failures++;
                    $display("FAIL swap_one_cycle got swap=%b want 0", swap_done);
                end
            end
            bus.pix_valid = (c < 5);
            bus.pix_x     = c;
            bus.pix_y     = 1;
            bus.pix_color = 16'(256 + c);
            frame_done    = (c == 4);
            vsync_in      = (c == 14);
            @(negedge clk_in);
        end
        bus.pix_valid = 1'b0;
        frame_done    = 1'b0;
        vsync_in      = 1'b0;
    endtask

    task automatic test_idle_drop();
        bus.pix_valid = 1'b1;
        bus.pix_x     = 5;
        bus.pix_y     = 5;
        vsync_in      = 1'b1;
        @(negedge clk_in);
        bus.pix_valid = 1'b0;
        vsync_in      = 1'b0;
        checks++;
        if ({drop_count, swap_done, disp_buf, busy} !== {16'd4, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL idle_drop got drop=%0d swap=%b dbuf=%b busy=%b want 4 0 1 0",
                     drop_count, swap_done, disp_buf, busy);
        end
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (bus.wr_en !== 1'b0) begin
                failures++;
                $display("FAIL idle_no_write c=%0d got en=%b want 0", c, bus.wr_en);
            end
            @(negedge clk_in);
        end
    endtask

    task automatic test_idle_swap();
        frame_done = 1'b1;
        @(negedge clk_in);
        frame_done = 1'b0;
        checks++;
        if ({busy, ready, bus.wr_en} !== 3'b100) begin
            failures++;
            $display("FAIL idle_to_drain got busy=%b rdy=%b en=%b want 1 0 0", busy, ready, bus.wr_en);
        end
        @(negedge clk_in);
        clear_start = 1'b1;
        @(negedge clk_in);
        clear_start = 1'b0;
        checks++;
        if ({busy, bus.wr_en, swap_done} !== 3'b100) begin
            failures++;
            $display("FAIL clear_ignored_in_wait got busy=%b en=%b swap=%b want 1 0 0", busy, bus.wr_en, swap_done);
        end
        vsync_in = 1'b1;
        @(negedge clk_in);
        vsync_in = 1'b0;
        checks++;
        if ({swap_done, disp_buf, bus.wr_buf, busy} !== 4'b1010) begin
            failures++;
            $display("FAIL swap_back got swap=%b dbuf=%b wbuf=%b busy=%b want 1 0 1 0",
                     swap_done, disp_buf, bus.wr_buf, busy);
        end
    endtask

    task automatic test_reset_mid_clear();
        int good = 0;
        clear_start = 1'b1;
        frame_done  = 1'b1;
        clear_color = 16'h5A5A;
        @(negedge clk_in);
        clear_start = 1'b0;
        frame_done  = 1'b0;
        for (int i = 0; i <= 1000; i++) begin
            if ({bus.wr_en, bus.wr_addr, bus.wr_data} === {1'b1, 16'(i), 16'h5A5A})
                good++;
            if (i == 1000) rst_in = 1'b1;
            @(negedge clk_in);
        end
        checks++;
        if (good !== 1001) begin
            failures++;
            $display("FAIL coincide_clear_wins got %0d correct words want 1001", good);
        end
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_buf, disp_buf, ready, busy, swap_done, drop_count}
            !== {1'b0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL reset_mid_clear got en=%b addr=%0d data=%h wbuf=%b dbuf=%b rdy=%b busy=%b swap=%b drop=%0d",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_buf, disp_buf, ready, busy, swap_done, drop_count);
        end
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if ({bus.wr_en, busy} !== 2'b00) begin
            failures++;
            $display("FAIL after_reset_mid_clear got en=%b busy=%b want 0 0", bus.wr_en, busy);
        end
    endtask

    initial begin
        bus.pix_valid = 1'b0;
        bus.pix_x     = 0;
        bus.pix_y     = 0;
        bus.pix_color = '0;
        test_reset();
        test_clear();
        test_pixel_write();
        test_bounds();
        test_vsync_ignored();
        test_back_to_back();
        test_idle_drop();
        test_idle_swap();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
